// File: rtl/cache_stats_pkg.sv
// Shared types and constants for the cache statistics tracker.
package cache_stats_pkg;

  typedef enum logic {
    IDLE,
    STREAM
  } dump_state_t;

  localparam int unsigned IDX_IMISS = 0;
  localparam int unsigned IDX_ICONF = 1;
  localparam int unsigned IDX_DMISS = 2;
  localparam int unsigned IDX_DCONF = 3;
  localparam int unsigned NUM_STATS = 4;

endpackage

// File: rtl/cpu_tracker_if.sv
// Counter interface between the cache statistics producer and the CPU tracker.
interface cpu_tracker_if;

  logic [31:0] icache_misses;
  logic [31:0] icache_conflicts;
  logic [31:0] dcache_misses;
  logic [31:0] dcache_conflicts;

  modport caches (
    output icache_misses,
    output icache_conflicts,
    output dcache_misses,
    output dcache_conflicts
  );

  modport tracker (
    input icache_misses,
    input icache_conflicts,
    input dcache_misses,
    input dcache_conflicts
  );

endinterface

// File: rtl/stat_counter.sv
// Single event counter with synchronous clear and optional saturation.
module stat_counter #(
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Clear has priority over an increment in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      if (!(SATURATE && (cnt == '1))) begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/cache_stats_tracker.sv
// Counts I$/D$ miss and conflict events onto cpu_tracker_if, with a clear
// handshake and a snapshot-and-stream dump port.
module cache_stats_tracker
  import cache_stats_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             icache_miss,
  input  logic             icache_conflict,
  input  logic             dcache_miss,
  input  logic             dcache_conflict,
  input  logic             count_en,
  input  logic             clear_req,
  output logic             clear_ack,
  input  logic             dump_req,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [1:0]       dump_idx,
  output logic [CNT_W-1:0] dump_data,
  output logic             dump_last,
  output logic             protocol_err,
  cpu_tracker_if.caches    tracker
);

  logic [NUM_STATS-1:0] inc;
  logic [CNT_W-1:0]     cnt  [NUM_STATS];
  logic [CNT_W-1:0]     snap [NUM_STATS];
  dump_state_t          state;
  logic [1:0]           next_idx;

  // Conflicts only count when qualified by a miss from the same cache.
  always_comb begin
    inc            = '0;
    inc[IDX_IMISS] = count_en & icache_miss;
    inc[IDX_ICONF] = count_en & icache_miss & icache_conflict;
    inc[IDX_DMISS] = count_en & dcache_miss;
    inc[IDX_DCONF] = count_en & dcache_miss & dcache_conflict;
  end

  stat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_imiss (
    .CLK(CLK), .RST(RST), .clr(clear_req), .inc(inc[IDX_IMISS]), .cnt(cnt[IDX_IMISS])
  );
  stat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_iconf (
    .CLK(CLK), .RST(RST), .clr(clear_req), .inc(inc[IDX_ICONF]), .cnt(cnt[IDX_ICONF])
  );
  stat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_dmiss (
    .CLK(CLK), .RST(RST), .clr(clear_req), .inc(inc[IDX_DMISS]), .cnt(cnt[IDX_DMISS])
  );
  stat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_dconf (
    .CLK(CLK), .RST(RST), .clr(clear_req), .inc(inc[IDX_DCONF]), .cnt(cnt[IDX_DCONF])
  );

  assign tracker.icache_misses    = 32'(cnt[IDX_IMISS]);
  assign tracker.icache_conflicts = 32'(cnt[IDX_ICONF]);
  assign tracker.dcache_misses    = 32'(cnt[IDX_DMISS]);
  assign tracker.dcache_conflicts = 32'(cnt[IDX_DCONF]);

  // Sticky flag for a conflict pulse that arrives without its miss.
  always_ff @(posedge CLK) begin
    if (RST) begin
      protocol_err <= 1'b0;
    end else if ((icache_conflict & ~icache_miss) | (dcache_conflict & ~dcache_miss)) begin
      protocol_err <= 1'b1;
    end
  end

  // The counters clear on the same edge, so the ack lands with the zeroed values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      clear_ack <= 1'b0;
    end else begin
      clear_ack <= clear_req;
    end
  end

  assign next_idx = dump_idx + 2'd1;

  // Dump FSM: snapshot on entry, then stream the four beats under valid/ready.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      snap       <= '{default: '0};
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_req) begin
            snap       <= cnt;
            state      <= STREAM;
            dump_valid <= 1'b1;
            dump_idx   <= '0;
            dump_data  <= cnt[IDX_IMISS];
            dump_last  <= 1'b0;
          end
        end
        STREAM: begin
          if (dump_ready) begin
            if (dump_idx == 2'(IDX_DCONF)) begin
              state      <= IDLE;
              dump_valid <= 1'b0;
              dump_idx   <= '0;
              dump_last  <= 1'b0;
            end else begin
              dump_idx  <= next_idx;
              dump_data <= snap[next_idx];
              dump_last <= (next_idx == 2'(IDX_DCONF));
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_stats_tracker.sv
// Scoreboard bench for cache_stats_tracker: stimulus queues hand-computed
// expectations, monitors on the falling edge pop and compare them.
module tb_cache_stats_tracker;

  logic CLK        = 1'b0;
  logic RST        = 1'b1;
  logic imiss      = 1'b0;
  logic iconf      = 1'b0;
  logic dmiss      = 1'b0;
  logic dconf      = 1'b0;
  logic count_en   = 1'b1;
  logic clear_req  = 1'b0;
  logic dump_req   = 1'b0;
  logic dump_ready = 1'b0;
  logic dmiss_s    = 1'b0;

  logic        clear_ack, dump_valid, dump_last, protocol_err;
  logic [1:0]  dump_idx;
  logic [31:0] dump_data;

  logic        sa_ack, sa_valid, sa_last, sa_perr;
  logic [1:0]  sa_idx;
  logic [3:0]  sa_data;
  logic        wa_ack, wa_valid, wa_last, wa_perr;
  logic [1:0]  wa_idx;
  logic [3:0]  wa_data;

  cpu_tracker_if trk_m ();
  cpu_tracker_if trk_s ();
  cpu_tracker_if trk_w ();

  always #5 CLK = ~CLK;

  cache_stats_tracker #(.CNT_W(32), .SATURATE(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .icache_miss(imiss), .icache_conflict(iconf),
    .dcache_miss(dmiss), .dcache_conflict(dconf),
    .count_en(count_en), .clear_req(clear_req), .clear_ack(clear_ack),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_last(dump_last),
    .protocol_err(protocol_err), .tracker(trk_m)
  );

  cache_stats_tracker #(.CNT_W(4), .SATURATE(1'b1)) dut_sat (
    .CLK(CLK), .RST(RST),
    .icache_miss(1'b0), .icache_conflict(1'b0),
    .dcache_miss(dmiss_s), .dcache_conflict(1'b0),
    .count_en(count_en), .clear_req(1'b0), .clear_ack(sa_ack),
    .dump_req(1'b0), .dump_valid(sa_valid), .dump_ready(1'b0),
    .dump_idx(sa_idx), .dump_data(sa_data), .dump_last(sa_last),
    .protocol_err(sa_perr), .tracker(trk_s)
  );

  cache_stats_tracker #(.CNT_W(4), .SATURATE(1'b0)) dut_wrap (
    .CLK(CLK), .RST(RST),
    .icache_miss(1'b0), .icache_conflict(1'b0),
    .dcache_miss(dmiss_s), .dcache_conflict(1'b0),
    .count_en(count_en), .clear_req(1'b0), .clear_ack(wa_ack),
    .dump_req(1'b0), .dump_valid(wa_valid), .dump_ready(1'b0),
    .dump_idx(wa_idx), .dump_data(wa_data), .dump_last(wa_last),
    .protocol_err(wa_perr), .tracker(trk_w)
  );

  typedef struct {
    int          cyc;
    int          unit;
    int          which;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  exp_t  sbq[$];
  beat_t beatq[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic string wname(int w);
    case (w)
      0: return "icache_misses";
      1: return "icache_conflicts";
      2: return "dcache_misses";
      3: return "dcache_conflicts";
      4: return "protocol_err";
      5: return "clear_ack";
      6: return "dump_valid";
      7: return "dump_idx";
      8: return "dump_data";
      9: return "dump_last";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] get_act(int u, int w);
    if (u == 1) return trk_s.dcache_misses;
    if (u == 2) return trk_w.dcache_misses;
    case (w)
      0: return trk_m.icache_misses;
      1: return trk_m.icache_conflicts;
      2: return trk_m.dcache_misses;
      3: return trk_m.dcache_conflicts;
      4: return 32'(protocol_err);
      5: return 32'(clear_ack);
      6: return 32'(dump_valid);
      7: return 32'(dump_idx);
      8: return dump_data;
      9: return 32'(dump_last);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: scalar expectations due this cycle, plus dump beats whenever valid.
  always @(negedge CLK) begin : mon
    exp_t        e;
    beat_t       b;
    logic [31:0] act;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e   = sbq.pop_front();
      act = get_act(e.unit, e.which);
      n_checks++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s unit%0d cyc%0d: got %0d expected %0d",
                 wname(e.which), e.unit, cyc, act, e.val);
      end
    end
    if (dump_valid === 1'b1) begin
      n_checks++;
      if (beatq.size() == 0) begin
        n_fail++;
        $display("FAIL dump_beat cyc%0d: got unexpected beat idx=%0d data=%0d, expected none",
                 cyc, dump_idx, dump_data);
      end else begin
        b = beatq[0];
        if (dump_idx !== b.idx || dump_data !== b.data || dump_last !== b.last) begin
          n_fail++;
          $display("FAIL dump_beat cyc%0d: got idx=%0d data=%0d last=%0b expected idx=%0d data=%0d last=%0b",
                   cyc, dump_idx, dump_data, dump_last, b.idx, b.data, b.last);
        end
        if (dump_ready) void'(beatq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(int d, int u, int w, logic [31:0] v);
    exp_t e;
    e.cyc   = cyc + d;
    e.unit  = u;
    e.which = w;
    e.val   = v;
    sbq.push_back(e);
  endtask

  task automatic push_cnts(int d, logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] e);
    push_exp(d, 0, 0, a);
    push_exp(d, 0, 1, b);
    push_exp(d, 0, 2, c);
    push_exp(d, 0, 3, e);
  endtask

  task automatic push_beat(logic [1:0] i, logic [31:0] dat, logic l);
    beat_t b;
    b.idx  = i;
    b.data = dat;
    b.last = l;
    beatq.push_back(b);
  endtask

  task automatic set_ev(logic a, logic b, logic c, logic d);
    imiss = a;
    iconf = b;
    dmiss = c;
    dconf = d;
  endtask

  task automatic build_3120();
    set_ev(1, 1, 1, 0); step();
    set_ev(1, 0, 1, 0); step();
    set_ev(1, 0, 0, 0); step();
    set_ev(0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    RST = 1'b1;
    step(); step();
    RST = 1'b0;
    push_cnts(0, 0, 0, 0, 0);
    for (int w = 4; w < 10; w++) push_exp(0, 0, w, 0);
    push_exp(0, 1, 2, 0);
    push_exp(0, 2, 2, 0);
    step();

    // 5 plain imiss + 2 with iconf; each count lags its pulse by one cycle
    for (int k = 0; k < 7; k++) begin
      set_ev(1, k >= 5, 0, 0);
      push_exp(0, 0, 0, 32'(k));
      push_exp(0, 0, 1, (k >= 5) ? 32'(k - 5) : 32'd0);
      step();
    end
    set_ev(0, 0, 0, 0);
    push_cnts(0, 7, 2, 0, 0);
    push_exp(0, 0, 4, 0);
    step();

    // dconf without dmiss: no count, sticky protocol_err
    set_ev(0, 0, 0, 1);
    push_exp(1, 0, 3, 0);
    push_exp(1, 0, 4, 1);
    step();
    set_ev(0, 0, 0, 0);
    step(); step();
    push_exp(0, 0, 4, 1);
    push_exp(0, 0, 3, 0);
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    push_cnts(0, 0, 0, 0, 0);
    push_exp(0, 0, 4, 0);
    step();

    // 4-bit counters: saturating vs wrapping, 20 dmiss pulses
    for (int k = 0; k < 20; k++) begin
      dmiss_s = 1'b1;
      if (k == 15) begin
        push_exp(0, 1, 2, 15);
        push_exp(0, 2, 2, 15);
      end
      if (k == 16) begin
        push_exp(0, 1, 2, 15);
        push_exp(0, 2, 2, 0);
      end
      step();
    end
    dmiss_s = 1'b0;
    push_exp(0, 1, 2, 15);
    push_exp(0, 2, 2, 4);
    step();

    // Clear wins over a same-cycle imiss; the next imiss counts from zero
    build_3120();
    set_ev(1, 0, 0, 0);
    clear_req = 1'b1;
    push_cnts(0, 3, 1, 2, 0);
    push_exp(0, 0, 5, 0);
    push_cnts(1, 0, 0, 0, 0);
    push_exp(1, 0, 5, 1);
    step();
    clear_req = 1'b0;
    push_cnts(1, 1, 0, 0, 0);
    push_exp(1, 0, 5, 0);
    step();
    set_ev(0, 0, 0, 0);

    // Held clear_req keeps clearing and keeps clear_ack high
    clear_req = 1'b1;
    push_exp(1, 0, 5, 1);
    step();
    set_ev(1, 0, 0, 0);
    push_cnts(1, 0, 0, 0, 0);
    push_exp(1, 0, 5, 1);
    step();
    clear_req = 1'b0;
    set_ev(0, 0, 0, 0);
    push_exp(1, 0, 5, 0);
    step();

    // Dump of (3,1,2,0) with toggling ready while imiss keeps counting
    build_3120();
    set_ev(1, 0, 0, 0);
    dump_req   = 1'b1;
    dump_ready = 1'b0;
    push_cnts(0, 3, 1, 2, 0);
    push_beat(0, 3, 0);
    push_beat(1, 1, 0);
    push_beat(2, 2, 0);
    push_beat(3, 0, 1);
    push_exp(0, 0, 6, 0);
    push_exp(1, 0, 6, 1);
    step();
    for (int k = 0; k < 7; k++) begin
      dump_ready = (k % 2 == 0);
      dump_req   = (k < 6);
      push_exp(0, 0, 0, 32'(4 + k));
      step();
    end
    set_ev(0, 0, 0, 0);
    dump_req   = 1'b0;
    dump_ready = 1'b0;
    push_exp(0, 0, 6, 0);
    push_exp(0, 0, 0, 11);
    step();

    // Reset during beat idx1 aborts the stream
    dump_req = 1'b1;
    push_beat(0, 11, 0);
    push_beat(1, 1, 0);
    step();
    dump_req   = 1'b0;
    dump_ready = 1'b1;
    step();
    RST = 1'b1;
    push_exp(1, 0, 6, 0);
    push_exp(1, 0, 7, 0);
    push_cnts(1, 0, 0, 0, 0);
    step();
    RST = 1'b0;
    step(); step();

    // A fresh dump starts from idx0 after the abort
    dump_req = 1'b1;
    push_beat(0, 0, 0);
    push_beat(1, 0, 0);
    push_beat(2, 0, 0);
    push_beat(3, 0, 1);
    step();
    dump_req = 1'b0;
    for (int k = 0; k < 4; k++) step();
    push_exp(0, 0, 6, 0);
    step();

    for (int k = 0; k < 10 && sbq.size() > 0; k++) step();
    n_checks++;
    if (beatq.size() != 0 || sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d beats and %0d checks pending, expected 0 and 0",
               beatq.size(), sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
